drivetrain_odometer: RTL
========================

// Module: drivetrain_odometer
// PURPOSE
//  Parametrised successor of the rpm->distance path for the drag-racing core.
//  Per 100 Hz tick: maps rpm and gear through a configurable ratio table to a
//  capped velocity; accumulates it with a fractional remainder (no truncation
//  loss); tracks absolute car position, race time and finish.
//  Sits between the engine/gearbox model and the track/renderer and score logic.
// PARAMETERS
//  RPM_W       14                     rpm input width
//  GEAR_W      3                      gear input width
//  N_GEARS     6                      valid gears 0..N_GEARS-1
//  RATIO_W     8                      width of one ratio entry
//  GEAR_RATIOS {40,32,25,18,13,9}x8b  packed table, gear i at [RATIO_W*i +: RATIO_W]
//  VEL_W       19                     velocity width
//  VEL_MAX     253952                 velocity cap (< 2**VEL_W)
//  FRAC_BITS   13                     fractional bits of velocity; DPOS_W = VEL_W-FRAC_BITS (6)
//  POS_W       16                     position counter width
//  FINISH_POS  40000                  finish line (< 2**POS_W)
//  TIME_W      16                     race-time tick counter width
// PORTS
//  clk100Hz      in   1          game tick clock
//  rst           in   1          synchronous active-high reset
//  reset_status  in   1          race restart; same effect as rst, synchronous
//  start         in   1          begin race (honoured only in IDLE)
//  rpm           in   RPM_W      engine speed
//  gear          in   GEAR_W     selected gear
//  velocity      out  VEL_W      registered capped velocity (fixed point, FRAC_BITS frac)
//  d_position    out  DPOS_W     integer distance advanced on last tick
//  position      out  POS_W      absolute position, saturates at FINISH_POS
//  race_time     out  TIME_W     ticks spent in RUN, saturating
//  running       out  1          high in RUN
//  finished      out  1          high in DONE
//  finish_pulse  out  1          one-cycle pulse on the RUN->DONE edge
// BEHAVIOUR
//  - rst or reset_status: every output and internal reg = 0; frac = 0; state = IDLE.
//    Both win over start and over any other event in the same cycle.
//  - Stage 1, every cycle, any state: prod = ratio[gear]*rpm at width RPM_W+RATIO_W.
//    gear >= N_GEARS -> prod = 0. velocity <= (prod > VEL_MAX) ? VEL_MAX : prod.
//  - Stage 2, RUN only: sum = frac + velocity. d_position <= sum >> FRAC_BITS.
//    frac <= sum[FRAC_BITS-1:0]. position += d_position value. race_time +1, sticks at all-ones.
//  - Latency: rpm/gear sampled at edge k -> velocity at k -> d_position/position at k+1.
//  - In IDLE and DONE: d_position = 0; position, frac and race_time hold.
//  - FSM:
//    IDLE -start-> RUN (first accumulation on the following edge).
//    RUN -(position + new d_position >= FINISH_POS)-> DONE.
//    On that edge: position = FINISH_POS, d_position = FINISH_POS - old position,
//      finish_pulse = 1 for that cycle only, race_time counts this tick.
//    DONE holds until rst or reset_status. start ignored in RUN and DONE.
//  - running/finished are registered decodes of state; no overlap.
// TESTING
//  1 start, gear0 rpm1000 -> velocity 9000. Tick1: d_position 1, frac 808.
//    After 8192 RUN ticks: position 9000 exactly, frac 0.
//  2 gear3 rpm16000 (prod 400000) -> velocity 253952. d_position 31 every tick, frac stays 0.
//  3 gear7 (>= N_GEARS), rpm 5000, in RUN -> velocity 0, d_position 0.
//    position holds; race_time still increments.
//  4 FINISH_POS=100, gear3 rpm16000 -> position 31,62,93,100.
//    Last tick: d_position 7, finish_pulse 1 for one cycle, finished 1. Afterwards d_position 0.
//  5 reset_status mid-RUN asserted together with start -> next edge all outputs 0, IDLE.
//    A start one cycle later re-launches from position 0.
//  6 TIME_W=4, start held high through RUN -> race_time saturates at 15.
//    No re-start; state stays RUN.

Source files
------------

// File: rtl/drivetrain_odometer.sv
// drivetrain_odometer: per-tick rpm/gear -> capped fixed-point velocity, then
// distance accumulation with a carried fractional remainder, absolute position,
// race time and finish detection for the drag-racing core.
module drivetrain_odometer #(
    parameter int RPM_W      = 14,
    parameter int GEAR_W     = 3,
    parameter int N_GEARS    = 6,
    parameter int RATIO_W    = 8,
    parameter logic [N_GEARS*RATIO_W-1:0] GEAR_RATIOS =
        {8'd40, 8'd32, 8'd25, 8'd18, 8'd13, 8'd9},
    parameter int VEL_W      = 19,
    parameter int VEL_MAX    = 253952,
    parameter int FRAC_BITS  = 13,
    parameter int POS_W      = 16,
    parameter int FINISH_POS = 40000,
    parameter int TIME_W     = 16
) (
    input  logic                       clk100Hz,
    input  logic                       rst,
    input  logic                       reset_status,
    input  logic                       start,
    input  logic [RPM_W-1:0]           rpm,
    input  logic [GEAR_W-1:0]          gear,
    output logic [VEL_W-1:0]           velocity,
    output logic [VEL_W-FRAC_BITS-1:0] d_position,
    output logic [POS_W-1:0]           position,
    output logic [TIME_W-1:0]          race_time,
    output logic                       running,
    output logic                       finished,
    output logic                       finish_pulse
);

    localparam int DPOS_W = VEL_W - FRAC_BITS;
    localparam int PROD_W = RPM_W + RATIO_W;
    localparam int SUM_W  = VEL_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state_q;
    logic [VEL_W-1:0]      vel_q;
    logic [FRAC_BITS-1:0]  frac_q;
    logic [DPOS_W-1:0]     dpos_q;
    logic [POS_W-1:0]      pos_q;
    logic [TIME_W-1:0]     time_q;
    logic                  running_q;
    logic                  finished_q;
    logic                  pulse_q;

    logic [RATIO_W-1:0]    ratio_d;
    logic [PROD_W-1:0]     prod_d;
    logic [SUM_W-1:0]      sum_d;
    logic [POS_W:0]        pos_next_d;
    logic                  reach_d;

    // Clamp the raw rpm*ratio product to the velocity ceiling.
    function automatic logic [VEL_W-1:0] cap_vel(input logic [PROD_W-1:0] p);
        if (p > PROD_W'(VEL_MAX))
            return VEL_W'(VEL_MAX);
        return p[VEL_W-1:0];
    endfunction

    // Race time counts up and sticks at all-ones instead of wrapping.
    function automatic logic [TIME_W-1:0] sat_time(input logic [TIME_W-1:0] t);
        if (&t)
            return t;
        return t + TIME_W'(1);
    endfunction

    // Ratio lookup (invalid gears give zero) and stage-2 accumulation arithmetic.
    always_comb begin
        ratio_d = '0;
        for (int i = 0; i < N_GEARS; i++) begin
            if (int'(gear) == i)
                ratio_d = GEAR_RATIOS[RATIO_W*i +: RATIO_W];
        end
        prod_d     = {{RPM_W{1'b0}}, ratio_d} * {{RATIO_W{1'b0}}, rpm};
        sum_d      = {1'b0, vel_q} + {{(SUM_W-FRAC_BITS){1'b0}}, frac_q};
        pos_next_d = {1'b0, pos_q} + (POS_W+1)'(sum_d[SUM_W-1:FRAC_BITS]);
        reach_d    = (pos_next_d >= (POS_W+1)'(FINISH_POS));
    end

    // Velocity stage every tick; race FSM and distance accumulation in RUN.
    always_ff @(posedge clk100Hz) begin
        if (rst || reset_status) begin
            state_q    <= S_IDLE;
            vel_q      <= '0;
            frac_q     <= '0;
            dpos_q     <= '0;
            pos_q      <= '0;
            time_q     <= '0;
            running_q  <= 1'b0;
            finished_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            vel_q   <= cap_vel(prod_d);
            dpos_q  <= '0;
            pulse_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    frac_q <= sum_d[FRAC_BITS-1:0];
                    time_q <= sat_time(time_q);
                    if (reach_d) begin
                        // Clip the last step so position lands exactly on the line.
                        dpos_q     <= DPOS_W'(POS_W'(FINISH_POS) - pos_q);
                        pos_q      <= POS_W'(FINISH_POS);
                        state_q    <= S_DONE;
                        running_q  <= 1'b0;
                        finished_q <= 1'b1;
                        pulse_q    <= 1'b1;
                    end else begin
                        dpos_q <= sum_d[FRAC_BITS +: DPOS_W];
                        pos_q  <= pos_next_d[POS_W-1:0];
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    running_q  <= 1'b0;
                    finished_q <= 1'b0;
                end
            endcase
        end
    end

    assign velocity     = vel_q;
    assign d_position   = dpos_q;
    assign position     = pos_q;
    assign race_time    = time_q;
    assign running      = running_q;
    assign finished     = finished_q;
    assign finish_pulse = pulse_q;

endmodule
